// File: rtl/mode_transition_controller.sv
`default_nettype none
// ============================================================================
// Module      : mode_transition_controller
// Description : Hood mode register. Arbitrates one-cycle toggle requests against
//               a legal-transition table and imposes a lockout window after each
//               change. Optional macro THIRD_ONCE_EN limits THIRD to one entry
//               per power cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_transition_controller #(
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int CNT_WIDTH      = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       power_toggle,
    input  logic       stand_mode_toggle,
    input  logic       first_mode_toggle,
    input  logic       second_mode_toggle,
    input  logic       third_mode_toggle,
    input  logic       clean_mode_toggle,
    input  logic       set_mode_toggle,
    output logic [2:0] current_mode,
    output logic [2:0] previous_mode,
    output logic       mode_changed,
    output logic       lockout_active,
    output logic       third_available
);

    localparam logic [2:0] OFF_MODE    = 3'd0;
    localparam logic [2:0] STAND_MODE  = 3'd1;
    localparam logic [2:0] FIRST_MODE  = 3'd2;
    localparam logic [2:0] SECOND_MODE = 3'd3;
    localparam logic [2:0] THIRD_MODE  = 3'd4;
    localparam logic [2:0] CLEAN_MODE  = 3'd5;
    localparam logic [2:0] SET_MODE    = 3'd6;

    localparam logic [CNT_WIDTH-1:0] LOCKOUT_LOAD = CNT_WIDTH'(LOCKOUT_CYCLES);

    logic [2:0]           next_mode;
    logic                 change;
    logic [CNT_WIDTH-1:0] lock_cnt;
    logic                 third_blocked;
    logic                 mode_valid;
    logic                 power_ok;
    logic                 stand_ok;
    logic                 first_ok;
    logic                 second_ok;
    logic                 third_ok;
    logic                 clean_ok;
    logic                 set_ok;

`ifdef THIRD_ONCE_EN
    logic third_used;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            third_used <= 1'b0;
        end else if (change && next_mode == THIRD_MODE) begin
            third_used <= 1'b1;
        end else if (change && next_mode == OFF_MODE) begin
            third_used <= 1'b0;
        end
    end

    assign third_blocked = third_used;
`else
    assign third_blocked = 1'b0;
`endif

    // State register: mode, history, change pulse and lockout counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            current_mode  <= OFF_MODE;
            previous_mode <= OFF_MODE;
            mode_changed  <= 1'b0;
            lock_cnt      <= '0;
        end else begin
            current_mode <= next_mode;
            mode_changed <= change;
            if (change) begin
                previous_mode <= current_mode;
                lock_cnt      <= LOCKOUT_LOAD;
            end else if (lock_cnt != '0) begin
                lock_cnt <= lock_cnt - CNT_WIDTH'(1);
            end
        end
    end

    // Next-state: legality filter, lockout gating, then fixed-priority pick
    always_comb begin
        mode_valid = (current_mode != 3'd7);
        power_ok   = power_toggle && (current_mode != OFF_MODE);
        stand_ok   = stand_mode_toggle && (current_mode != STAND_MODE);
        first_ok   = first_mode_toggle &&
                     (current_mode == STAND_MODE || current_mode == SECOND_MODE);
        second_ok  = second_mode_toggle &&
                     (current_mode == STAND_MODE || current_mode == FIRST_MODE);
        third_ok   = third_mode_toggle && (current_mode == STAND_MODE) && !third_blocked;
        clean_ok   = clean_mode_toggle && (current_mode == STAND_MODE);
        set_ok     = set_mode_toggle && (current_mode == STAND_MODE);

        next_mode = current_mode;
        if (!mode_valid) begin
            next_mode = OFF_MODE;
        end else if (power_ok) begin
            next_mode = OFF_MODE;
        end else if (lock_cnt == '0) begin
            if (stand_ok) begin
                next_mode = STAND_MODE;
            end else if (clean_ok) begin
                next_mode = CLEAN_MODE;
            end else if (set_ok) begin
                next_mode = SET_MODE;
            end else if (third_ok) begin
                next_mode = THIRD_MODE;
            end else if (second_ok) begin
                next_mode = SECOND_MODE;
            end else if (first_ok) begin
                next_mode = FIRST_MODE;
            end
        end
        change = (next_mode != current_mode);
    end

    // Output decode
    always_comb begin
        lockout_active  = (lock_cnt != '0);
        third_available = ~third_blocked;
    end

endmodule
`default_nettype wire

// File: tb/tb_mode_transition_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_transition_controller
// Description : Directed self-checking bench, LOCKOUT_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_transition_controller;

    localparam logic [2:0] OFF_M    = 3'd0;
    localparam logic [2:0] STAND_M  = 3'd1;
    localparam logic [2:0] FIRST_M  = 3'd2;
    localparam logic [2:0] SECOND_M = 3'd3;
    localparam logic [2:0] THIRD_M  = 3'd4;
    localparam logic [2:0] CLEAN_M  = 3'd5;

    // Toggle vector bit order: {power, stand, first, second, third, clean, set}
    localparam logic [6:0] T_NONE   = 7'b0000000;
    localparam logic [6:0] T_POWER  = 7'b1000000;
    localparam logic [6:0] T_STAND  = 7'b0100000;
    localparam logic [6:0] T_FIRST  = 7'b0010000;
    localparam logic [6:0] T_SECOND = 7'b0001000;
    localparam logic [6:0] T_THIRD  = 7'b0000100;
    localparam logic [6:0] T_CLEAN  = 7'b0000010;
    localparam logic [6:0] T_SET    = 7'b0000001;

    logic       clk = 1'b0;
    logic       rstn;
    logic       power_toggle, stand_mode_toggle, first_mode_toggle, second_mode_toggle;
    logic       third_mode_toggle, clean_mode_toggle, set_mode_toggle;
    logic [2:0] current_mode, previous_mode;
    logic       mode_changed, lockout_active, third_available;

    int checks   = 0;
    int failures = 0;

    mode_transition_controller #(
        .LOCKOUT_CYCLES(4),
        .CNT_WIDTH     (3)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .power_toggle      (power_toggle),
        .stand_mode_toggle (stand_mode_toggle),
        .first_mode_toggle (first_mode_toggle),
        .second_mode_toggle(second_mode_toggle),
        .third_mode_toggle (third_mode_toggle),
        .clean_mode_toggle (clean_mode_toggle),
        .set_mode_toggle   (set_mode_toggle),
        .current_mode      (current_mode),
        .previous_mode     (previous_mode),
        .mode_changed      (mode_changed),
        .lockout_active    (lockout_active),
        .third_available   (third_available)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_toggles(input logic [6:0] t);
        {power_toggle, stand_mode_toggle, first_mode_toggle, second_mode_toggle,
         third_mode_toggle, clean_mode_toggle, set_mode_toggle} = t;
    endtask

    // Present toggles for one rising edge; returns at the following falling edge
    task automatic cycle(input logic [6:0] t);
        set_toggles(t);
        @(negedge clk);
        set_toggles(T_NONE);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(T_NONE);
    endtask

    task automatic check_mode(input string tag, input logic [2:0] m, input logic mc);
        check({tag, "_mode"}, 32'(current_mode), 32'(m));
        check({tag, "_chg"}, 32'(mode_changed), 32'(mc));
    endtask

    initial begin
        set_toggles(T_NONE);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", 32'(current_mode), 32'(OFF_M));
        check("rst_prev", 32'(previous_mode), 32'(OFF_M));
        check("rst_chg", 32'(mode_changed), 32'(0));
        check("rst_lock", 32'(lockout_active), 32'(0));
        check("rst_third", 32'(third_available), 32'(1));
        rstn = 1'b1;
        @(negedge clk);

        // OFF -> STAND, lockout 4 cycles, single-cycle change pulse
        cycle(T_STAND);
        check_mode("t1_enter", STAND_M, 1'b1);
        check("t1_prev", 32'(previous_mode), 32'(OFF_M));
        check("t1_lock0", 32'(lockout_active), 32'(1));
        cycle(T_NONE);
        check("t1_chg_pulse", 32'(mode_changed), 32'(0));
        check("t1_lock1", 32'(lockout_active), 32'(1));
        cycle(T_NONE);
        check("t1_lock2", 32'(lockout_active), 32'(1));

        // First toggle inside lockout is dropped
        cycle(T_FIRST);
        check_mode("t2_locked", STAND_M, 1'b0);
        check("t2_lock3", 32'(lockout_active), 32'(1));
        cycle(T_NONE);
        check("t2_lock_end", 32'(lockout_active), 32'(0));
        cycle(T_FIRST);
        check_mode("t2_first", FIRST_M, 1'b1);
        check("t2_prev", 32'(previous_mode), 32'(STAND_M));

        // Power overrides lockout and reloads it to the full window
        cycle(T_POWER);
        check_mode("t3_power", OFF_M, 1'b1);
        check("t3_prev", 32'(previous_mode), 32'(FIRST_M));
        idle(3);
        check("t3_reload", 32'(lockout_active), 32'(1));
        cycle(T_NONE);
        check("t3_reload_end", 32'(lockout_active), 32'(0));

        // Illegal toggles in OFF
        cycle(T_FIRST);
        check_mode("t5_first", OFF_M, 1'b0);
        cycle(T_CLEAN);
        check_mode("t5_clean", OFF_M, 1'b0);
        cycle(T_POWER);
        check_mode("t5_power", OFF_M, 1'b0);
        check("t5_lock", 32'(lockout_active), 32'(0));

        // Simultaneous clean+set+first: clean wins, losers not queued
        cycle(T_STAND);
        idle(4);
        cycle(T_CLEAN | T_SET | T_FIRST);
        check_mode("t4_clean", CLEAN_M, 1'b1);
        check("t4_prev", 32'(previous_mode), 32'(STAND_M));
        idle(5);
        check_mode("t4_hold", CLEAN_M, 1'b0);
        cycle(T_FIRST);
        check_mode("t4_illegal", CLEAN_M, 1'b0);
        cycle(T_POWER | T_STAND);
        check_mode("prio_power", OFF_M, 1'b1);

        // second beats first; FIRST from SECOND; re-requesting current mode is a no-op
        idle(4);
        cycle(T_STAND);
        idle(4);
        cycle(T_SECOND | T_FIRST);
        check_mode("prio_second", SECOND_M, 1'b1);
        idle(4);
        cycle(T_FIRST);
        check_mode("second_to_first", FIRST_M, 1'b1);
        idle(4);
        cycle(T_FIRST);
        check_mode("same_mode", FIRST_M, 1'b0);
        check("same_mode_lock", 32'(lockout_active), 32'(0));

        // THIRD re-entry behaviour
        cycle(T_STAND);
        idle(4);
        cycle(T_THIRD);
        check_mode("t6_third1", THIRD_M, 1'b1);
`ifdef THIRD_ONCE_EN
        check("t6_avail_used", 32'(third_available), 32'(0));
`else
        check("t6_avail_used", 32'(third_available), 32'(1));
`endif
        idle(4);
        cycle(T_STAND);
        idle(4);
        cycle(T_THIRD);
`ifdef THIRD_ONCE_EN
        check_mode("t6_third2", STAND_M, 1'b0);
        check("t6_avail2", 32'(third_available), 32'(0));
`else
        check_mode("t6_third2", THIRD_M, 1'b1);
        check("t6_avail2", 32'(third_available), 32'(1));
`endif
        cycle(T_POWER);
        check_mode("t6_off", OFF_M, 1'b1);
        check("t6_avail_off", 32'(third_available), 32'(1));
        idle(4);
        cycle(T_STAND);
        idle(4);
        cycle(T_THIRD);
        check_mode("t6_third3", THIRD_M, 1'b1);

        // Asynchronous reset in the middle of a lockout window
        cycle(T_POWER);
        check("mid_lock", 32'(lockout_active), 32'(1));
        #2 rstn = 1'b0;
        #1;
        check("arst_mode", 32'(current_mode), 32'(OFF_M));
        check("arst_prev", 32'(previous_mode), 32'(OFF_M));
        check("arst_chg", 32'(mode_changed), 32'(0));
        check("arst_lock", 32'(lockout_active), 32'(0));
        check("arst_third", 32'(third_available), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
